// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Default geometry matches the MIPS integer register bank.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;
  localparam int NREGS_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [NREGS_DEF-1:0] pend_vec_t;

  // Source selected by a read port's output mux.
  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_WA    = 2'd1,
    SRC_WB    = 2'd2,
    SRC_ZERO  = 2'd3
  } rd_src_e;

  function automatic logic [ADDR_W_DEF:0] popcount(input pend_vec_t v);
    logic [ADDR_W_DEF:0] n;
    n = '0;
    for (int i = 0; i < NREGS_DEF; i++) begin
      n = n + {{ADDR_W_DEF{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bundle of the register file: read ports,
// two write ports, issue port and the pending-count status.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) ();

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wa_en;
  logic [ADDR_W-1:0]     wa_addr;
  logic [DATA_W-1:0]     wa_data;
  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic [ADDR_W:0]       pend_cnt;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr,
    input  rd_data, rd_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr,
    output rd_data, rd_busy, pend_cnt
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, with issue taking priority so a newly issued producer stays outstanding.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wa_en,
  input  logic [ADDR_W-1:0]      wa_addr,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] pending_nxt_s;
  logic [ADDR_W:0]  pend_cnt_r;
  logic [ADDR_W:0]  pend_cnt_nxt_s;

  // Next pending vector: set wins over clear, register 0 optionally pinned low.
  always_comb begin
    pending_nxt_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      if ((ZERO_REG != 0) && (i == 0)) begin
        pending_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = (iss_en && (iss_addr == ADDR_W'(i))) ||
                           (pending_r[i] &&
                            !((wa_en && (wa_addr == ADDR_W'(i))) ||
                              (wb_en && (wb_addr == ADDR_W'(i)))));
      end
    end
  end

  // The count is taken from the next vector so it lands on the same edge.
  if (NREGS <= NREGS_DEF) begin : g_pkg_pop
    pend_vec_t pend_ext_s;
    always_comb begin
      pend_ext_s              = '0;
      pend_ext_s[NREGS-1:0]   = pending_nxt_s;
      pend_cnt_nxt_s          = (ADDR_W+1)'(popcount(pend_ext_s));
    end
  end else begin : g_loc_pop
    always_comb begin
      pend_cnt_nxt_s = '0;
      for (int i = 0; i < NREGS; i++) begin
        pend_cnt_nxt_s = pend_cnt_nxt_s + {{ADDR_W{1'b0}}, pending_nxt_s[i]};
      end
    end
  end

  // Pending vector and its population count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_r  <= '0;
      pend_cnt_r <= '0;
    end else begin
      pending_r  <= pending_nxt_s;
      pend_cnt_r <= pend_cnt_nxt_s;
    end
  end

  assign pending  = pending_r;
  assign pend_cnt = pend_cnt_r;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: storage, two write ports with B priority,
// combinational read ports with optional write-to-read bypass, plus a pending scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  reg_file_mp_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]     regs_r [NREGS];
  logic [NREGS-1:0]      pending_s;
  logic [ADDR_W:0]       pend_cnt_s;
  logic [ADDR_W-1:0]     rd_addr_s [NRD];
  rd_src_e               rd_src_s  [NRD];
  logic [NRD-1:0]        wa_hit_s;
  logic [NRD-1:0]        wb_hit_s;
  logic [NRD*DATA_W-1:0] rd_data_s;
  logic [NRD-1:0]        rd_busy_s;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .wa_en    (bus.wa_en),
    .wa_addr  (bus.wa_addr),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .pending  (pending_s),
    .pend_cnt (pend_cnt_s)
  );

  // Storage update; port B wins when both ports target the same register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if ((ZERO_REG != 0) && (i == 0)) begin
          regs_r[i] <= '0;
        end else if (bus.wb_en && (bus.wb_addr == ADDR_W'(i))) begin
          regs_r[i] <= bus.wb_data;
        end else if (bus.wa_en && (bus.wa_addr == ADDR_W'(i))) begin
          regs_r[i] <= bus.wa_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Per-port source selection and the read data / busy muxes.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    wa_hit_s  = '0;
    wb_hit_s  = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr_s[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
      wa_hit_s[k]  = bus.wa_en && (bus.wa_addr == rd_addr_s[k]);
      wb_hit_s[k]  = bus.wb_en && (bus.wb_addr == rd_addr_s[k]);
      if ((ZERO_REG != 0) && (rd_addr_s[k] == '0)) begin
        rd_src_s[k] = SRC_ZERO;
      end else if ((BYPASS != 0) && wb_hit_s[k]) begin
        rd_src_s[k] = SRC_WB;
      end else if ((BYPASS != 0) && wa_hit_s[k]) begin
        rd_src_s[k] = SRC_WA;
      end else begin
        rd_src_s[k] = SRC_STORE;
      end
      case (rd_src_s[k])
        SRC_ZERO:  rd_data_s[k*DATA_W +: DATA_W] = '0;
        SRC_WB:    rd_data_s[k*DATA_W +: DATA_W] = bus.wb_data;
        SRC_WA:    rd_data_s[k*DATA_W +: DATA_W] = bus.wa_data;
        SRC_STORE: rd_data_s[k*DATA_W +: DATA_W] = regs_r[rd_addr_s[k]];
        default:   rd_data_s[k*DATA_W +: DATA_W] = '0;
      endcase
      // A bypassed write satisfies the reader, so the stall is dropped early.
      if ((rd_src_s[k] == SRC_WB) || (rd_src_s[k] == SRC_WA)) begin
        rd_busy_s[k] = 1'b0;
      end else begin
        rd_busy_s[k] = pending_s[rd_addr_s[k]];
      end
    end
  end

  assign bus.rd_data  = rd_data_s;
  assign bus.rd_busy  = rd_busy_s;
  assign bus.pend_cnt = pend_cnt_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypass and a no-bypass 32x32 instance driven in lockstep
// from a vector table, plus a 4-port 8x16 instance exercised by a short sequence.
module tb_reg_file_mp;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_a ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_b ();
  reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NRD(4)) if_c ();

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(if_a.slave)
  );
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(if_b.slave)
  );
  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(if_c.slave)
  );

  typedef struct {
    logic        rst_n;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] a_d0;
    logic [31:0] a_d1;
    logic [31:0] b_d0;
    logic [31:0] b_d1;
    logic [1:0]  a_busy;
    logic [1:0]  b_busy;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
      input logic rst_n, input logic wa_en, input logic [4:0] wa_addr, input logic [31:0] wa_data,
      input logic wb_en, input logic [4:0] wb_addr, input logic [31:0] wb_data,
      input logic iss_en, input logic [4:0] iss_addr, input logic [4:0] ra0, input logic [4:0] ra1,
      input logic [31:0] a_d0, input logic [31:0] a_d1, input logic [31:0] b_d0, input logic [31:0] b_d1,
      input logic [1:0] a_busy, input logic [1:0] b_busy, input logic [5:0] cnt);
    vec_t v;
    v.rst_n = rst_n;   v.wa_en = wa_en;   v.wa_addr = wa_addr;   v.wa_data = wa_data;
    v.wb_en = wb_en;   v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.iss_en = iss_en; v.iss_addr = iss_addr; v.ra0 = ra0; v.ra1 = ra1;
    v.a_d0 = a_d0; v.a_d1 = a_d1; v.b_d0 = b_d0; v.b_d1 = b_d1;
    v.a_busy = a_busy; v.b_busy = b_busy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n       = v.rst_n;
    if_a.wa_en    = v.wa_en;    if_b.wa_en    = v.wa_en;
    if_a.wa_addr  = v.wa_addr;  if_b.wa_addr  = v.wa_addr;
    if_a.wa_data  = v.wa_data;  if_b.wa_data  = v.wa_data;
    if_a.wb_en    = v.wb_en;    if_b.wb_en    = v.wb_en;
    if_a.wb_addr  = v.wb_addr;  if_b.wb_addr  = v.wb_addr;
    if_a.wb_data  = v.wb_data;  if_b.wb_data  = v.wb_data;
    if_a.iss_en   = v.iss_en;   if_b.iss_en   = v.iss_en;
    if_a.iss_addr = v.iss_addr; if_b.iss_addr = v.iss_addr;
    if_a.rd_addr  = {v.ra1, v.ra0};
    if_b.rd_addr  = {v.ra1, v.ra0};
  endtask

  initial begin
    vec_t v;
    vec_t e;

    // Reads of every address after reset: all zero, nothing pending.
    for (int a = 0; a < 32; a++) begin
      tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                       5'(a), 5'(31 - a), 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    end
    // Same-address double write: B wins, bypass shows it in the same cycle.
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0,
                     32'h12345678, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
                     32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 2'b00, 2'b00, 6'd0));
    // Register 0 ignores writes and issues.
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5,
                     32'h0, 32'h12345678, 32'h0, 32'h12345678, 2'b00, 2'b00, 6'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    // r7: issue, re-issue with writeback (set wins), then plain writeback clears.
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd7, 32'hAAAA0007, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0,
                     32'hAAAA0007, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 6'd1));
    tbl.push_back(mk(1'b1, 1'b1, 5'd7, 32'hBBBB0007, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
                     32'hBBBB0007, 32'h12345678, 32'hAAAA0007, 32'h12345678, 2'b00, 2'b01, 6'd1));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
                     32'hBBBB0007, 32'h12345678, 32'hBBBB0007, 32'h12345678, 2'b00, 2'b00, 6'd0));
    // Issue r1, r2, r3 back to back; count steps up.
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd1, 5'd2,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd1, 5'd2,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 6'd1));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd2, 5'd3,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 6'd2));
    // Reset cycle with a writeback to r2: the write must be dropped.
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd3, 5'd1,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 2'b11, 6'd3));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd7,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    // Independent writes on both ports.
    tbl.push_back(mk(1'b1, 1'b1, 5'd10, 32'h0000000A, 1'b1, 5'd11, 32'h0000000B, 1'b0, 5'd0, 5'd10, 5'd11,
                     32'h0000000A, 32'h0000000B, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11,
                     32'h0000000A, 32'h0000000B, 32'h0000000A, 32'h0000000B, 2'b00, 2'b00, 6'd0));
    // Issue and port-B writeback to r12 together: r12 ends up pending.
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h0000000C, 1'b1, 5'd12, 5'd12, 5'd0,
                     32'h0000000C, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0,
                     32'h0000000C, 32'h0, 32'h0000000C, 32'h0, 2'b01, 2'b01, 6'd1));

    // Initial reset with every input idle.
    drive(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
             32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    if_c.wa_en = 1'b0; if_c.wa_addr = 3'd0; if_c.wa_data = 16'h0;
    if_c.wb_en = 1'b0; if_c.wb_addr = 3'd0; if_c.wb_data = 16'h0;
    if_c.iss_en = 1'b0; if_c.iss_addr = 3'd0; if_c.rd_addr = 12'h0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      v = tbl[i];
      drive(v);
      exp_q.push_back(v);
      @(negedge clock);
      if (exp_q.size() == 0) begin
        chk("queue_empty", i, 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("a_rd0",   i, 64'(if_a.rd_data[31:0]),  64'(e.a_d0));
        chk("a_rd1",   i, 64'(if_a.rd_data[63:32]), 64'(e.a_d1));
        chk("b_rd0",   i, 64'(if_b.rd_data[31:0]),  64'(e.b_d0));
        chk("b_rd1",   i, 64'(if_b.rd_data[63:32]), 64'(e.b_d1));
        chk("a_busy",  i, 64'(if_a.rd_busy),        64'(e.a_busy));
        chk("b_busy",  i, 64'(if_b.rd_busy),        64'(e.b_busy));
        chk("a_pcnt",  i, 64'(if_a.pend_cnt),       64'(e.cnt));
        chk("b_pcnt",  i, 64'(if_b.pend_cnt),       64'(e.cnt));
      end
      @(posedge clock);
    end

    // Four-port instance: two cycles of dual writes, then all ports read at once.
    #1;
    drive(mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
             32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0));
    if_c.wa_en = 1'b1; if_c.wa_addr = 3'd1; if_c.wa_data = 16'h0011;
    if_c.wb_en = 1'b1; if_c.wb_addr = 3'd2; if_c.wb_data = 16'h0022;
    @(posedge clock);
    #1;
    if_c.wa_addr = 3'd3; if_c.wa_data = 16'h0033;
    if_c.wb_addr = 3'd4; if_c.wb_data = 16'h0044;
    @(posedge clock);
    #1;
    if_c.wa_en = 1'b0; if_c.wb_en = 1'b0;
    if_c.rd_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    @(negedge clock);
    chk("c_rd0",  100, 64'(if_c.rd_data[15:0]),  64'h0011);
    chk("c_rd1",  100, 64'(if_c.rd_data[31:16]), 64'h0022);
    chk("c_rd2",  100, 64'(if_c.rd_data[47:32]), 64'h0033);
    chk("c_rd3",  100, 64'(if_c.rd_data[63:48]), 64'h0044);
    chk("c_busy", 100, 64'(if_c.rd_busy),        64'h0);
    chk("c_pcnt", 100, 64'(if_c.pend_cnt),       64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the single-cycle MIPS datapath, succeeding the fixed 32×32, two-read/one-write register bank. It adds configurable width/depth/read-port count, a second write port, hardwired-zero register 0, optional same-cycle write-to-read bypass, synchronous clear, and a per-register pending-write scoreboard. Sits between decode (read and issue addresses) and writeback (ALU and load results).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count NREGS = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of a register being written this cycle returns the new data; 0 = returns the stored value
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues

- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  pending-write flag for each read address
- wa_en, wa_addr, wa_data  in  1/ADDR_W/DATA_W  write port A (ALU writeback)
- wb_en, wb_addr, wb_data  in  1/ADDR_W/DATA_W  write port B (load writeback)
- iss_en, iss_addr  in  1/ADDR_W  issue: mark destination register pending
- pend_cnt  out  ADDR_W+1  registered count of pending registers

## Operation
- Reset (reset_n=0 at an edge): all registers cleared to 0, all pending bits cleared, pend_cnt=0. Outputs follow: rd_data=0, rd_busy=0. Writes and issues in a reset cycle are discarded.
- Write: at an edge, wa_en stores wa_data at wa_addr and wb_en stores wb_data at wb_addr. Same address on both ports: B wins, A discarded.
- Read: rd_data[k] = regs[rd_addr[k]]. With ZERO_REG=1, address 0 always reads 0.
- Bypass (BYPASS=1): if wb_en and wb_addr==rd_addr[k], return wb_data; else if wa_en and wa_addr==rd_addr[k], return wa_data; else the stored value. Never applied to address 0 when ZERO_REG=1.
- Scoreboard: pending[i] next = set_i | (pending[i] & ~clr_i).
  - set_i = iss_en & iss_addr==i.
  - clr_i = (wa_en & wa_addr==i) | (wb_en & wb_addr==i).
  - Set beats clear when issue and writeback hit the same register in one cycle: the new producer is outstanding.
  - Issue to an already-pending register leaves it set.
  - With ZERO_REG=1, pending[0] is constant 0.
- rd_busy[k] = pending[rd_addr[k]], cleared combinationally when BYPASS=1 and a write to that address is active this cycle.
- pend_cnt = population count of the pending vector, registered; it equals the count of the pending vector after the same edge.

## Timing
- Write latency 1 edge; without bypass, a read sees the data the cycle after the write.
- Read and bypass paths are purely combinational: zero cycles.
- Scoreboard set and clear take effect at the edge and are visible on rd_busy from the next cycle, apart from the same-cycle bypass clear above.
- pend_cnt is updated at the same edge as the pending vector; no extra lag.
- No handshake backpressure; the caller stalls on rd_busy.

## Structure
- Package reg_file_pkg: default DATA_W/ADDR_W/NRD constants and a popcount function sized by NREGS.
- Sub-module reg_scoreboard: pending vector, set/clear priority, and the pend_cnt register. The storage array, write priority and read/bypass muxes stay in the top module.

## Test plan
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, pend_cnt=0.
- wa writes 0xDEADBEEF to r5 and wb writes 0x12345678 to r5 in the same cycle -> r5 reads 0x12345678 after the edge. With BYPASS=1 the same cycle also reads 0x12345678; with BYPASS=0 it reads the old value, 0.
- Write 0xFFFFFFFF to r0 and issue r0 -> r0 reads 0, rd_busy=0, pend_cnt=0.
- Issue r7 -> rd_busy=1 and pend_cnt=1 next cycle. Issue r7 again while wa writes r7 -> stays busy, pend_cnt=1. Write r7 alone -> busy clears, pend_cnt=0.
- Issue r1, r2, r3 on three consecutive cycles -> pend_cnt steps 1, 2, 3. Assert reset_n=0 while wb writes r2 -> all state cleared, r2 reads 0.
- NRD=4, DATA_W=16, ADDR_W=3: four ports read r1..r4 simultaneously after distinct writes 0x0011..0x0044 -> each port returns its own value.
